// File: rtl/regfile_dec_pkg.sv
// Shared defaults for the decoded register file.
// Integrators can import these values instead of repeating literal widths.
package regfile_dec_pkg;

  localparam int unsigned DefaultDw = 8;
  localparam int unsigned DefaultAw = 3;

endpackage

// File: rtl/regfile_dec_dec_onehot.sv
// Binary-to-one-hot decoder with enable.
// The output is all zero while en is low.
module dec_onehot #(
  parameter int unsigned AW = 3
) (
  input  logic [AW-1:0]      in,
  input  logic               en,
  output logic [(1<<AW)-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/regfile_dec.sv
// Register file of 2**AW entries with decoded write enable and per-entry valid bits.
// The read port is registered, with an optional same-cycle write-to-read bypass.
module regfile_dec
  import regfile_dec_pkg::*;
#(
  parameter int unsigned DW     = DefaultDw,
  parameter int unsigned AW     = DefaultAw,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic                clr,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       rdata,
  output logic                rvalid,
  output logic                rhit,
  output logic [(1<<AW)-1:0]  wsel,
  output logic [(1<<AW)-1:0]  valid_vec
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   mem_q [NREG];
  logic [NREG-1:0] valid_q, valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rhit_q, rhit_d;
  logic            fwd;

  dec_onehot #(
    .AW (AW)
  ) u_dec (
    .in  (waddr),
    .en  (we),
    .out (wsel)
  );

  always_comb begin
    // Write wins over clear for its own entry.
    valid_d = (clr ? '0 : valid_q) | wsel;
    fwd     = (BYPASS != 0) && we && (waddr == raddr);
    rdata_d = rdata_q;
    rhit_d  = rhit_q;
    if (re) begin
      rdata_d = fwd ? wdata : mem_q[raddr];
      rhit_d  = fwd ? 1'b1 : valid_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wsel[i]) mem_q[i] <= wdata;
      end
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      rvalid_q <= re;
      rhit_q   <= rhit_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rhit      = rhit_q;
  assign valid_vec = valid_q;

endmodule

// File: tb/tb_regfile_dec.sv
// Bench for regfile_dec: bypass and non-bypass instances share stimulus and
// are checked against a reference model through an expected-read queue.
module tb_regfile_dec;

  logic       clk = 1'b0;
  logic       rst, we, clr, re;
  logic [2:0] waddr, raddr;
  logic [7:0] wdata;

  logic [7:0] rdata1, rdata0, wsel1, wsel0, vv1, vv0;
  logic       rvalid1, rvalid0, rhit1, rhit0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] d1;
    logic       h1;
    logic [7:0] d0;
    logic       h0;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last = '0;
  logic [7:0] mem_m [8];
  logic [7:0] val_m = '0;

  always #5 clk = ~clk;

  regfile_dec #(.DW(8), .AW(3), .BYPASS(1)) u_dut1 (
    .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata), .clr (clr),
    .re (re), .raddr (raddr), .rdata (rdata1), .rvalid (rvalid1), .rhit (rhit1),
    .wsel (wsel1), .valid_vec (vv1)
  );

  regfile_dec #(.DW(8), .AW(3), .BYPASS(0)) u_dut0 (
    .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata), .clr (clr),
    .re (re), .raddr (raddr), .rdata (rdata0), .rvalid (rvalid0), .rhit (rhit0),
    .wsel (wsel0), .valid_vec (vv0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus: r=rst, w=we, c=clr, rd=re.
  task automatic cyc(input logic r, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                     input logic c, input logic rd, input logic [2:0] ra);
    exp_t       e;
    logic [7:0] ews;
    rst = r; we = w; waddr = wa; wdata = wd; clr = c; re = rd; raddr = ra;
    #1;
    ews = w ? (8'h01 << wa) : 8'h00;
    chk("wsel_byp", {24'h0, wsel1}, {24'h0, ews});
    chk("wsel_nobyp", {24'h0, wsel0}, {24'h0, ews});
    if (rd && !r) begin
      e.d0 = mem_m[ra];
      e.h0 = val_m[ra];
      e.d1 = (w && wa == ra) ? wd : mem_m[ra];
      e.h1 = (w && wa == ra) ? 1'b1 : val_m[ra];
      sb_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
      val_m = 8'h00;
    end else begin
      if (c) val_m = 8'h00;
      if (w) begin
        mem_m[wa] = wd;
        val_m[wa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      sb_q.delete();
      last = '0;
      chk("rst_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      chk("rst_rdata", {16'h0, rdata1, rdata0}, 32'h0);
      chk("rst_rhit", {30'h0, rhit1, rhit0}, 32'h0);
    end else if (rd) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        last = e;
        chk("rvalid", {30'h0, rvalid1, rvalid0}, 32'h3);
        chk("rdata_byp", {24'h0, rdata1}, {24'h0, e.d1});
        chk("rhit_byp", {31'h0, rhit1}, {31'h0, e.h1});
        chk("rdata_nobyp", {24'h0, rdata0}, {24'h0, e.d0});
        chk("rhit_nobyp", {31'h0, rhit0}, {31'h0, e.h0});
      end
    end else begin
      chk("idle_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      chk("hold_rdata", {16'h0, rdata1, rdata0}, {16'h0, last.d1, last.d0});
      chk("hold_rhit", {30'h0, rhit1, rhit0}, {30'h0, last.h1, last.h0});
    end
    chk("valid_vec_byp", {24'h0, vv1}, {24'h0, val_m});
    chk("valid_vec_nobyp", {24'h0, vv0}, {24'h0, val_m});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    // Reset, then read every address back to back.
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 0, 1, 3'(i));
    chk("reset_vv", {24'h0, vv1}, 32'h00);

    // Single write then read.
    cyc(0, 1, 5, 8'hA5, 0, 0, 0);
    chk("write5_vv", {24'h0, vv1}, 32'h20);
    cyc(0, 0, 0, 8'h00, 0, 1, 5);
    chk("read5_data", {24'h0, rdata1}, 32'hA5);

    // Same-cycle write and read of addr 3.
    cyc(0, 1, 3, 8'h11, 0, 0, 0);
    cyc(0, 1, 3, 8'h3C, 0, 1, 3);
    chk("bypass_on", {24'h0, rdata1}, 32'h3C);
    chk("bypass_off", {24'h0, rdata0}, 32'h11);
    cyc(0, 0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 1, 3);

    // Fill, then clear alongside a write to addr 2.
    for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), 8'(8'h10 + i * 8'h21), 0, 0, 0);
    cyc(0, 1, 2, 8'h77, 1, 0, 0);
    chk("clr_write_vv", {24'h0, vv1}, 32'h04);
    cyc(0, 0, 0, 8'h00, 0, 1, 6);
    chk("clr_read6_hit", {31'h0, rhit1}, 32'h0);
    cyc(0, 0, 0, 8'h00, 0, 1, 2);

    // Read during clear sees the pre-clear valid bit.
    cyc(0, 0, 0, 8'h00, 1, 1, 2);
    chk("clr_read_hit", {31'h0, rhit1}, 32'h1);

    // Back-to-back reads with no bubbles.
    cyc(0, 0, 0, 8'h00, 0, 1, 1);
    cyc(0, 0, 0, 8'h00, 0, 1, 2);
    cyc(0, 0, 0, 8'h00, 0, 1, 3);

    // Reset the cycle after a read, and reset together with a read.
    cyc(0, 0, 0, 8'h00, 0, 1, 7);
    cyc(1, 1, 4, 8'hEE, 1, 1, 4);
    cyc(0, 0, 0, 8'h00, 0, 1, 7);
    cyc(1, 0, 0, 8'h00, 0, 1, 7);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 0, 1, 3'(i));
    cyc(0, 0, 0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
